// File: rtl/word_serializer_p.sv
// word_serializer_p: WORD_W-to-LANE_W serializer with a one-word pending buffer on clk_4f.
// Lane order is MSB-first unless WORDSER_LSB_FIRST_EN is defined, which gives LSB-first.
module word_serializer_p #(
    parameter int WORD_W = 32,
    parameter int LANE_W = 8
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [WORD_W-1:0] Data_in,
    output logic              ready_out,
    output logic              valid_out,
    output logic [LANE_W-1:0] data_out,
    output logic              last_out,
    output logic              busy_out
);
    localparam int NUM_LANES = WORD_W / LANE_W;
    localparam int CW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;

    if (WORD_W % LANE_W != 0 || NUM_LANES < 1) begin : g_bad_widths
        $error("word_serializer_p: WORD_W must be a positive multiple of LANE_W");
    end

    logic [WORD_W-1:0] r_word, r_pend;
    logic [CW-1:0]     r_cnt;
    logic              r_act, r_pend_v;
    logic              w_acc, w_emit, w_last;
    logic [WORD_W-1:0] w_src;
    logic [CW-1:0]     w_idx;
    logic [LANE_W-1:0] w_lane;

    function automatic logic [LANE_W-1:0] lane(input logic [WORD_W-1:0] w, input logic [CW-1:0] i);
`ifdef WORDSER_LSB_FIRST_EN
        return w[LANE_W*int'(i) +: LANE_W];
`else
        return w[WORD_W-LANE_W-LANE_W*int'(i) +: LANE_W];
`endif
    endfunction

    assign ready_out = !r_pend_v & !reset;
    assign busy_out  = r_act | r_pend_v;
    assign w_acc     = valid_in & ready_out;

    // Source priority: active word, then pending word, then a bypassing input word.
    always_comb begin
        w_emit = r_act | r_pend_v | w_acc;
        w_src  = r_act ? r_word : (r_pend_v ? r_pend : Data_in);
        w_idx  = r_act ? r_cnt : '0;
        w_last = w_idx == CW'(NUM_LANES-1);
        w_lane = lane(w_src, w_idx);
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            r_word    <= '0;
            r_pend    <= '0;
            r_cnt     <= '0;
            r_act     <= 1'b0;
            r_pend_v  <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= w_emit;
            data_out  <= w_emit ? w_lane : '0;
            last_out  <= w_emit & w_last;
            if (w_emit) begin
                r_word <= w_src;
                r_cnt  <= w_last ? '0 : w_idx + 1'b1;
                r_act  <= !w_last;
            end
            if (r_act & w_acc) begin
                r_pend   <= Data_in;
                r_pend_v <= 1'b1;
            end else if (!r_act) begin
                r_pend_v <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_word_serializer_p.sv
// tb_word_serializer_p: random and directed stimulus checked every cycle against a lane-queue model.
module tb_word_serializer_p;
    localparam int W = 32;
    localparam int L = 8;
    localparam int N = W / L;

    typedef struct {
        logic [L-1:0] d;
        logic         l;
    } lane_t;

    logic         clk_4f = 1'b0;
    logic         reset = 1'b1;
    logic         valid_in = 1'b0;
    logic [W-1:0] Data_in = '0;
    logic         ready_out, valid_out, last_out, busy_out;
    logic [L-1:0] data_out;

    int checks = 0;
    int errors = 0;

    lane_t        q[$];
    logic         m_valid = 1'b0, m_last = 1'b0;
    logic [L-1:0] m_data = '0;
    logic [L-1:0] got[$];
    logic         got_last[$];

    word_serializer_p #(.WORD_W(W), .LANE_W(L)) dut (
        .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .Data_in(Data_in),
        .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
        .last_out(last_out), .busy_out(busy_out)
    );

    always #5 clk_4f = ~clk_4f;

    function automatic logic [L-1:0] lane_of(logic [W-1:0] w, int i);
`ifdef WORDSER_LSB_FIRST_EN
        return w[i*L +: L];
`else
        return w[W-1-i*L -: L];
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted word appends its lanes to a queue; each edge emits the queue head.
    // A full unstarted word waiting in the queue is exactly the pending register being occupied.
    always @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            q.delete();
            m_valid = 1'b0; m_data = '0; m_last = 1'b0;
        end else begin
            if (valid_in && q.size() < N)
                for (int i = 0; i < N; i++) q.push_back('{lane_of(Data_in, i), i == N-1});
            if (q.size() > 0) begin
                lane_t h;
                h = q.pop_front();
                m_valid = 1'b1; m_data = h.d; m_last = h.l;
            end else begin
                m_valid = 1'b0; m_data = '0; m_last = 1'b0;
            end
        end
    end

    always @(negedge clk_4f) begin
        chk("valid_out", valid_out, m_valid);
        chk("data_out", data_out, m_data);
        chk("last_out", last_out, m_last);
        chk("busy_out", busy_out, q.size() > 0);
        chk("ready_out", ready_out, !reset && q.size() < N);
        if (valid_out === 1'b1) begin
            got.push_back(data_out);
            got_last.push_back(last_out);
        end
    end

    task automatic drive(logic v, logic [W-1:0] d);
        @(posedge clk_4f);
        #2;
        valid_in = v;
        Data_in  = d;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom);
    endtask

    // Literal lane bytes are written MSB-first; reverse each word's group for LSB-first builds.
    task automatic chk_seq(string name, logic [L-1:0] exp[$]);
        logic [L-1:0] e[$];
        e = exp;
`ifdef WORDSER_LSB_FIRST_EN
        for (int w = 0; w < exp.size() / N; w++)
            for (int i = 0; i < N; i++) e[w*N+i] = exp[w*N+N-1-i];
`endif
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk({name, "_lane"}, got[i], e[i]);
            chk({name, "_last"}, got_last[i], (i % N) == N-1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) drive(1'($urandom), $urandom);
        chk("reset_valid", valid_out, 0);
        chk("reset_ready", ready_out, 0);
        chk("reset_busy", busy_out, 0);
        drive(1'b0, '0);
        reset = 1'b0;
        #1 chk("ready_after_release", ready_out, 1);

        got.delete(); got_last.delete();
        drive(1'b1, 32'hA1B2C3D4);
        drive(1'b0, '0);
        idle(5);
        chk_seq("single", '{8'hA1, 8'hB2, 8'hC3, 8'hD4});
        chk("single_busy", busy_out, 0);

        got.delete(); got_last.delete();
        drive(1'b1, 32'h11223344);
        drive(1'b1, 32'h55667788);
        drive(1'b0, '0);
        #1 chk("b2b_ready_low", ready_out, 0);
        idle(9);
        chk_seq("b2b", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});

        got.delete(); got_last.delete();
        drive(1'b1, 32'hDEADBEEF);
        drive(1'b0, '0);
        idle(5);
        chk_seq("drop_valid", '{8'hDE, 8'hAD, 8'hBE, 8'hEF});

        drive(1'b1, 32'h11223344);
        drive(1'b1, 32'h55667788);
        drive(1'b0, '0);
        chk("pend_busy", busy_out, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_last", last_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_ready", ready_out, 0);
        idle(2);
        reset = 1'b0;
        got.delete(); got_last.delete();
        drive(1'b1, 32'hCAFEF00D);
        drive(1'b0, '0);
        idle(6);
        chk_seq("after_reset", '{8'hCA, 8'hFE, 8'hF0, 8'h0D});

        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 9) < 6, $urandom);
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b1;
                idle(2);
                reset = 1'b0;
            end
        end
        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
